uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data bus beside `data_mem`, downstream of the `riscv_cpu` load/store port. The top-level address decoder asserts `sel` for this block's 16-byte window; the block decodes `addr[3:2]`. CPU stores push bytes into a small FIFO, and a baud-divided FSM serialises them 8N1 on `tx`. Loads return status and configuration combinationally in the same cycle, matching `data_mem` read behaviour.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_tx_mmio.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM type, register map and STATUS layout for the MMIO UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_COUNT   = 3;
  localparam int STAT_COUNT_W = 3;
  localparam int STAT_OVF     = 6;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers and same-edge push/pop on full
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             push_ok
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // The head slot is vacated on the same edge, so a full FIFO can still take a byte.
  assign push_ok = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq
);

  localparam int                   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  uart_state_e          state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] bit_cnt;
  logic [DIV_WIDTH-1:0] div_wr;
  logic [7:0]           shift;
  logic [2:0]           bit_idx;
  logic                 ctrl_en;
  logic                 ctrl_irq_en;
  logic                 ovf;
  logic [1:0]           reg_idx;
  logic                 wr_sel;
  logic                 rd_sel;
  logic                 txdata_wr;
  logic                 push_ok;
  logic                 pop;
  logic                 bit_done;
  logic                 busy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;
  logic [CW-1:0]        fifo_count;
  logic [31:0]          count_ext;
  logic                 unused_bits;

  assign reg_idx     = addr[3:2];
  assign wr_sel      = sel && wr_en;
  assign rd_sel      = sel && rd_en;
  assign txdata_wr   = wr_sel && (reg_idx == UART_TXDATA[3:2]);
  assign div_wr      = wr_data[DIV_WIDTH-1:0];
  assign count_ext   = 32'(fifo_count);
  assign busy        = (state != ST_IDLE);
  assign bit_done    = (bit_cnt == '0);
  assign pop         = ctrl_en && !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
  assign unused_bits = ^{addr, wr_data, count_ext};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (txdata_wr),
    .wdata  (wr_data[7:0]),
    .pop    (pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count),
    .push_ok(push_ok)
  );

  always_comb begin
    rd_data = '0;
    if (rd_sel) begin
      case (reg_idx)
        UART_STATUS[3:2]: begin
          rd_data[STAT_FULL]                     = fifo_full;
          rd_data[STAT_EMPTY]                    = fifo_empty;
          rd_data[STAT_BUSY]                     = busy;
          rd_data[STAT_COUNT +: STAT_COUNT_W]    = count_ext[STAT_COUNT_W-1:0];
          rd_data[STAT_OVF]                      = ovf;
        end
        UART_DIV[3:2]:  rd_data = 32'(div_q);
        UART_CTRL[3:2]: rd_data[1:0] = {ctrl_irq_en, ctrl_en};
        default:        rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= DIV_DEFAULT;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (txdata_wr && !push_ok) ovf <= 1'b1;
      if (wr_sel) begin
        case (reg_idx)
          UART_STATUS[3:2]: ovf <= 1'b0;
          UART_DIV[3:2]:    div_q <= (div_wr == '0) ? DIV_ONE : div_wr;
          UART_CTRL[3:2]: begin
            ctrl_en     <= wr_data[0];
            ctrl_irq_en <= wr_data[1];
          end
          default: ;
        endcase
      end
    end
  end

  // The divisor is sampled only when a bit starts, so DIV writes land on the next bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      irq     <= 1'b0;
    end else begin
      irq <= ctrl_irq_en && fifo_empty && !busy;
      if (pop) begin
        state   <= ST_START;
        shift   <= fifo_head;
        bit_cnt <= div_q - DIV_ONE;
        tx      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: tx <= 1'b1;
          ST_START: begin
            if (bit_done) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= div_q - DIV_ONE;
            end else begin
              bit_cnt <= bit_cnt - DIV_ONE;
            end
          end
          ST_DATA: begin
            if (bit_done) begin
              bit_cnt <= div_q - DIV_ONE;
              if (bit_idx == 3'd7) begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx      <= shift[0];
                shift   <= {1'b0, shift[7:1]};
              end
            end else begin
              bit_cnt <= bit_cnt - DIV_ONE;
            end
          end
          ST_STOP: begin
            if (bit_done) state <= ST_IDLE;
            else          bit_cnt <= bit_cnt - DIV_ONE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for the MMIO UART transmitter
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        tx;
  logic        irq;

  typedef struct packed {
    logic [7:0]      data;
    logic [9:0][7:0] dur;
    int              start_cyc;
    logic            b2b;
  } frame_t;

  frame_t      exp_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b1;
  logic        mon_busy = 1'b0;

  uart_tx_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .addr   (addr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .tx     (tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] d);
    sel = 1'b1; wr_en = 1'b1; addr = {28'h4000_100, off}; wr_data = d;
    @(posedge clk); #1;
    sel = 1'b0; wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic bus_rd(input logic [3:0] off, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    sel = 1'b1; rd_en = 1'b1; addr = {28'h4000_100, off};
    @(posedge clk); #1;
    sel = 1'b0; rd_en = 1'b0;
  endtask

  // First n_lo bit cells (start bit is cell 0) last dv_lo cycles, the rest dv_hi.
  task automatic push_frame(input logic [7:0] d, input int dv_lo, input int dv_hi,
                            input int n_lo, input int start, input logic b2b);
    frame_t f;
    f.data = d;
    for (int b = 0; b < 10; b++) f.dur[b] = (b < n_lo) ? 8'(dv_lo) : 8'(dv_hi);
    f.start_cyc = start;
    f.b2b = b2b;
    exp_q.push_back(f);
  endtask

  task automatic wait_frames(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("frame_timeout", 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : rd_monitor
    logic [31:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (sel === 1'b1 && rd_en === 1'b1) begin
        chk("rd_expected", 32'(rd_exp_q.size() != 0), 32'd1);
        if (rd_exp_q.size() != 0) begin
          e  = rd_exp_q.pop_front();
          nm = rd_name_q.pop_front();
          chk(nm, rd_data, e);
        end
      end
    end
  end

  initial begin : frame_monitor
    logic       tx_prev;
    logic       ok;
    logic [9:0] bits;
    int         last_end;
    frame_t     f;
    tx_prev  = 1'b1;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b1 && tx_prev === 1'b1 && tx === 1'b0) begin
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) begin
          tx_prev = tx;
        end else begin
          mon_busy = 1'b1;
          f = exp_q.pop_front();
          if (f.start_cyc >= 0) chk("frame_start_cycle", 32'(cyc), 32'(f.start_cyc));
          if (f.b2b) chk("frame_gap", 32'(cyc), 32'(last_end + 1));
          bits = {1'b1, f.data, 1'b0};
          for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < int'(f.dur[b]); c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (tx !== bits[b]) ok = 1'b0;
            end
            chk($sformatf("frame_%02h_cell%0d", f.data, b), 32'(ok), 32'd1);
          end
          last_end = cyc;
          tx_prev  = 1'b1;
          mon_busy = 1'b0;
        end
      end else begin
        tx_prev = tx;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b0; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    tick(1);

    bus_rd(4'h4, 32'h02, "reset_status");
    bus_rd(4'h8, 32'd434, "reset_div");
    bus_rd(4'hC, 32'h0, "reset_ctrl");
    bus_rd(4'h0, 32'h0, "txdata_reads_zero");
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_irq", 32'(irq), 32'd0);

    // single frame, start one cycle after the capturing edge
    bus_wr(4'h8, 32'd4);
    bus_wr(4'hC, 32'd1);
    bus_rd(4'h8, 32'd4, "div_readback");
    bus_rd(4'hC, 32'd1, "ctrl_readback");
    bus_wr(4'h0, 32'hA5);
    push_frame(8'hA5, 4, 4, 10, cyc + 1, 1'b0);
    bus_rd(4'h4, 32'h08, "status_before_pop");
    bus_rd(4'h4, 32'h06, "status_after_pop");
    wait_frames(200);
    bus_rd(4'h4, 32'h02, "status_after_frame");
    chk("irq_disabled", 32'(irq), 32'd0);

    // fill, overflow, clear, then drain back-to-back
    bus_wr(4'hC, 32'd0);
    bus_wr(4'h0, 32'h11);
    bus_wr(4'h0, 32'h22);
    bus_wr(4'h0, 32'h33);
    bus_wr(4'h0, 32'h44);
    bus_wr(4'h0, 32'h55);
    bus_rd(4'h4, 32'h61, "status_full_ovf");
    bus_wr(4'h4, 32'h0);
    bus_rd(4'h4, 32'h21, "status_ovf_cleared");
    push_frame(8'h11, 4, 4, 10, -1, 1'b0);
    push_frame(8'h22, 4, 4, 10, -1, 1'b1);
    push_frame(8'h33, 4, 4, 10, -1, 1'b1);
    push_frame(8'h44, 4, 4, 10, -1, 1'b1);
    bus_wr(4'hC, 32'd1);
    wait_frames(400);
    bus_rd(4'h4, 32'h02, "status_drained");

    // push on full landing on the pop edge
    bus_wr(4'hC, 32'd0);
    bus_wr(4'h0, 32'h01);
    bus_wr(4'h0, 32'h02);
    bus_wr(4'h0, 32'h03);
    bus_wr(4'h0, 32'h04);
    bus_rd(4'h4, 32'h21, "status_full_again");
    push_frame(8'h01, 4, 4, 10, -1, 1'b0);
    push_frame(8'h02, 4, 4, 10, -1, 1'b1);
    push_frame(8'h03, 4, 4, 10, -1, 1'b1);
    push_frame(8'h04, 4, 4, 10, -1, 1'b1);
    push_frame(8'h05, 4, 4, 10, -1, 1'b1);
    bus_wr(4'hC, 32'd1);
    bus_wr(4'h0, 32'h05);
    bus_rd(4'h4, 32'h25, "status_push_on_pop");
    wait_frames(500);
    bus_rd(4'h4, 32'h02, "status_no_ovf");

    // DIV edge cases
    bus_wr(4'h8, 32'd0);
    bus_rd(4'h8, 32'd1, "div_zero_stores_one");
    bus_wr(4'h8, 32'd4);
    bus_wr(4'h0, 32'h3C);
    push_frame(8'h3C, 4, 8, 3, cyc + 1, 1'b0);
    tick(9);
    bus_wr(4'h8, 32'd8);
    wait_frames(200);
    bus_rd(4'h8, 32'd8, "div_after_change");
    bus_wr(4'h8, 32'd4);

    // drain interrupt
    bus_wr(4'hC, 32'd3);
    tick(2);
    chk("irq_idle_empty", 32'(irq), 32'd1);
    bus_wr(4'h0, 32'h96);
    push_frame(8'h96, 4, 4, 10, cyc + 1, 1'b0);
    tick(5);
    chk("irq_low_busy", 32'(irq), 32'd0);
    wait_frames(200);
    chk("irq_not_early", 32'(irq), 32'd0);
    tick(1);
    chk("irq_after_stop", 32'(irq), 32'd1);

    // reset mid-frame
    mon_en = 1'b0;
    bus_wr(4'h0, 32'h00);
    bus_wr(4'h0, 32'h81);
    tick(10);
    chk("tx_low_mid_frame", 32'(tx), 32'd0);
    bus_rd(4'h4, 32'h0C, "status_mid_frame");
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_tx", 32'(tx), 32'd1);
    chk("async_reset_irq", 32'(irq), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    bus_rd(4'h4, 32'h02, "status_after_reset");
    bus_rd(4'hC, 32'h0, "ctrl_after_reset");
    bus_rd(4'h8, 32'd434, "div_after_reset");
    mon_en = 1'b1;
    tick(20);
    chk("tx_idle_after_reset", 32'(tx), 32'd1);
    chk("irq_after_reset", 32'(irq), 32'd0);

    chk("frames_left", 32'(exp_q.size()), 32'd0);
    chk("reads_left", 32'(rd_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
